// File: rtl/fpu_pkg.sv
// FPU CSR shared definitions: FCSR field positions, cause/flag indices, FSM state.
package fpu_pkg;
  localparam int RM_LSB  = 0;
  localparam int FLG_LSB = 2;
  localparam int EN_LSB  = 7;
  localparam int CAU_LSB = 12;
  localparam int FCC_BIT = 23;

  // cause / flag / enable field bit order {V,Z,O,U,I}
  localparam int C_I = 0;
  localparam int C_U = 1;
  localparam int C_O = 2;
  localparam int C_Z = 3;
  localparam int C_V = 4;

  // res_flags = {zero,dbz,qnan,snan,inexact,underflow,overflow}
  localparam int F_OVF  = 0;
  localparam int F_UNF  = 1;
  localparam int F_INX  = 2;
  localparam int F_SNAN = 3;
  localparam int F_QNAN = 4;
  localparam int F_DBZ  = 5;
  localparam int F_ZERO = 6;

  typedef enum logic {IDLE = 1'b0, TRAP_PENDING = 1'b1} state_t;

  function automatic logic [4:0] op_cause(input logic [6:0] f);
    logic [4:0] c;
    c      = '0;
    c[C_V] = f[F_SNAN] | f[F_QNAN];
    c[C_Z] = f[F_DBZ];
    c[C_O] = f[F_OVF];
    c[C_U] = f[F_UNF];
    c[C_I] = f[F_INX];
    return c;
  endfunction
endpackage

// File: rtl/fpu_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module fpu_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && ~&cnt)     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fpu_csr.sv
// FP status/control register with exception trap FSM and writeback stage.
// Optional stats word (op/trap counters) built when FPU_CSR_STATS_EN is defined.
module fpu_csr
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_data,
  input  logic [6:0]  res_flags,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  input  logic        csr_sel,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        trap_req,
  input  logic        trap_ack
);
  state_t     state;
  logic [1:0] rm;
  logic [4:0] flags, en, cause;
  logic       fcc;
  logic [4:0] cur_cause;
  logic       accept, trap_hit, fcsr_we;
  logic [31:0] fcsr, stats;

  assign res_ready = (state == IDLE) && !csr_we;
  assign accept    = res_valid && res_ready;
  assign cur_cause = op_cause(res_flags);
  assign trap_hit  = |(cur_cause & en);
  assign fcsr_we   = csr_we && !csr_sel;
  assign trap_req  = (state == TRAP_PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rm       <= '0;
      flags    <= '0;
      en       <= '0;
      cause    <= '0;
      fcc      <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (state == TRAP_PENDING && trap_ack) state <= IDLE;
      // accept is impossible during a CSR write, so the two never collide
      if (fcsr_we) begin
        rm    <= csr_wdata[RM_LSB +: 2];
        flags <= csr_wdata[FLG_LSB +: 5];
        en    <= csr_wdata[EN_LSB +: 5];
        cause <= csr_wdata[CAU_LSB +: 5];
        fcc   <= csr_wdata[FCC_BIT];
      end else if (accept) begin
        cause <= cur_cause;
        if (trap_hit) begin
          state <= TRAP_PENDING;
        end else begin
          flags    <= flags | cur_cause;
          fcc      <= res_flags[F_ZERO];
          wb_valid <= 1'b1;
          wb_data  <= res_data;
        end
      end
    end
  end

  always_comb begin
    fcsr                    = '0;
    fcsr[RM_LSB +: 2]       = rm;
    fcsr[FLG_LSB +: 5]      = flags;
    fcsr[EN_LSB +: 5]       = en;
    fcsr[CAU_LSB +: 5]      = cause;
    fcsr[FCC_BIT]           = fcc;
  end

`ifdef FPU_CSR_STATS_EN
  logic [15:0] op_cnt, trap_cnt;
  logic        stats_clr;
  assign stats_clr = csr_we && csr_sel;

  fpu_sat_counter #(.W(16)) u_op_cnt (
    .clk(clk), .rst_n(rst_n), .inc(accept), .clr(stats_clr), .cnt(op_cnt)
  );
  fpu_sat_counter #(.W(16)) u_trap_cnt (
    .clk(clk), .rst_n(rst_n), .inc(accept && trap_hit), .clr(stats_clr), .cnt(trap_cnt)
  );
  assign stats = {trap_cnt, op_cnt};
`else
  assign stats = '0;
`endif

  assign csr_rdata = csr_sel ? stats : fcsr;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, csr_wdata[31:24], csr_wdata[22:17]};
endmodule

// File: tb/tb_fpu_csr.sv
// Directed self-checking bench for fpu_csr (also covers FPU_CSR_STATS_EN when defined).
module tb_fpu_csr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [6:0]  res_flags;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        csr_sel, csr_we;
  logic [31:0] csr_wdata, csr_rdata;
  logic        trap_req, trap_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_csr dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .csr_sel(csr_sel), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .trap_req(trap_req), .trap_ack(trap_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_fcsr(input logic [31:0] d);
    csr_we = 1'b1; csr_sel = 1'b0; csr_wdata = d;
    step();
    csr_we = 1'b0; csr_wdata = '0;
  endtask

  // one-cycle accept; flags = {zero,dbz,qnan,snan,inexact,underflow,overflow}
  task automatic push(input logic [31:0] d, input logic [6:0] f);
    res_valid = 1'b1; res_data = d; res_flags = f;
    step();
    res_valid = 1'b0; res_flags = '0;
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 0; res_data = '0; res_flags = '0;
    csr_sel = 0; csr_we = 0; csr_wdata = '0; trap_ack = 0;
    #12;
    chk("rst_trap",  {31'd0, trap_req}, 32'd0);
    chk("rst_wbv",   {31'd0, wb_valid}, 32'd0);
    chk("rst_wbd",   wb_data, 32'd0);
    chk("rst_fcsr",  csr_rdata, 32'd0);
    chk("rst_ready", {31'd0, res_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // clean inexact result
    push(32'h3F800000, 7'b0000100);
    chk("inx_wbv",  {31'd0, wb_valid}, 32'd1);
    chk("inx_wbd",  wb_data, 32'h3F800000);
    chk("inx_fcsr", csr_rdata, 32'h00001004);
    step();
    chk("inx_wbv_1cyc", {31'd0, wb_valid}, 32'd0);

    // zero flag sets FCC, cause clears, sticky inexact kept
    push(32'h00000000, 7'b1000000);
    chk("fcc_fcsr", csr_rdata, 32'h00800004);

    // enabled divide-by-zero traps
    wr_fcsr(32'h00000400);
    chk("enz_fcsr", csr_rdata, 32'h00000400);
    push(32'h12345678, 7'b0100000);
    chk("dbz_trap",  {31'd0, trap_req}, 32'd1);
    chk("dbz_ready", {31'd0, res_ready}, 32'd0);
    chk("dbz_wbv",   {31'd0, wb_valid}, 32'd0);
    chk("dbz_fcsr",  csr_rdata, 32'h00008400);
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    chk("ack_trap",  {31'd0, trap_req}, 32'd0);
    chk("ack_ready", {31'd0, res_ready}, 32'd1);

    // ack while idle is ignored
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    chk("idle_ack", {31'd0, trap_req}, 32'd0);

    // simultaneous csr write and trap ack
    push(32'h1, 7'b0100000);
    chk("t2_trap", {31'd0, trap_req}, 32'd1);
    trap_ack = 1'b1; wr_fcsr(32'h0); trap_ack = 1'b0;
    chk("we_ack_trap", {31'd0, trap_req}, 32'd0);
    chk("we_ack_fcsr", csr_rdata, 32'd0);

    // back-to-back overflow, underflow, clean
    res_valid = 1'b1;
    res_data = 32'hA; res_flags = 7'b0000001; step();
    chk("b2b1_wbv", {31'd0, wb_valid}, 32'd1);
    chk("b2b1_fcsr", csr_rdata, 32'h00004010);
    res_data = 32'hB; res_flags = 7'b0000010; step();
    chk("b2b2_wbd", wb_data, 32'hB);
    chk("b2b2_fcsr", csr_rdata, 32'h00002018);
    res_data = 32'hC; res_flags = 7'b0000000; step();
    res_valid = 1'b0;
    chk("b2b3_wbv", {31'd0, wb_valid}, 32'd1);
    chk("b2b3_wbd", wb_data, 32'hC);
    chk("b2b3_fcsr", csr_rdata, 32'h00000018);

    // csr write with cause&enables nonzero never traps; blocks accept
    csr_we = 1'b1; csr_sel = 1'b0; csr_wdata = 32'h0001F800; res_valid = 1'b1; res_flags = 7'b0;
    #1;
    chk("we_ready", {31'd0, res_ready}, 32'd0);
    step();
    csr_we = 1'b0; res_valid = 1'b0;
    chk("we_notrap", {31'd0, trap_req}, 32'd0);
    chk("we_nowb",   {31'd0, wb_valid}, 32'd0);
    chk("we_fcsr",   csr_rdata, 32'h0001F800);

    // undefined bits read zero, RM stored
    wr_fcsr(32'hFFFFFFFF);
    chk("mask_fcsr",  csr_rdata, 32'h0081FFFF);
    chk("mask_notrap", {31'd0, trap_req}, 32'd0);

`ifndef FPU_CSR_STATS_EN
    csr_sel = 1'b1; #1;
    chk("stats_off_rd", csr_rdata, 32'd0);
    csr_we = 1'b1; csr_wdata = 32'hFFFFFFFF; step(); csr_we = 1'b0;
    chk("stats_off_wr", csr_rdata, 32'd0);
    csr_sel = 1'b0; #1;
    chk("stats_off_fcsr", csr_rdata, 32'h0081FFFF);
`endif

    // async reset mid-trap
    wr_fcsr(32'h00000400);
    push(32'h2, 7'b0100000);
    chk("t3_trap", {31'd0, trap_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_trap", {31'd0, trap_req}, 32'd0);
    chk("areset_fcsr", csr_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef FPU_CSR_STATS_EN
    csr_sel = 1'b1; #1;
    chk("stats_rst", csr_rdata, 32'd0);
    csr_sel = 1'b0;
    res_valid = 1'b1; res_flags = 7'b0;
    for (int i = 0; i < 65540; i++) step();
    res_valid = 1'b0;
    csr_sel = 1'b1; #1;
    chk("stats_sat", csr_rdata, 32'h0000FFFF);
    csr_sel = 1'b0;
    wr_fcsr(32'h00000400);
    push(32'h3, 7'b0100000);
    csr_sel = 1'b1; #1;
    chk("stats_trap", csr_rdata, 32'h0001FFFF);
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    csr_we = 1'b1; csr_wdata = 32'h0; step(); csr_we = 1'b0;
    chk("stats_clr", csr_rdata, 32'd0);
    csr_sel = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_csr.md
FPU_CSR -- requirements
Module: fpu_csr

Interface
REQ-001 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-002 rst_n  in  1  reset; asynchronous, active-low.
REQ-003 res_valid  in  1  FP ALU result present this cycle.
REQ-004 res_ready  out  1  result accepted when res_valid&res_ready.
REQ-005 res_data  in  32  FP ALU result word.
REQ-006 res_flags  in  7  {zero,dbz,qnan,snan,inexact,underflow,overflow} from the FP ALU.
REQ-007 wb_valid  out  1  writeback strobe.
REQ-008 wb_data  out  32  registered result.
REQ-009 csr_sel  in  1  0=FCSR, 1=stats word.
REQ-010 csr_we  in  1  software write strobe.
REQ-011 csr_wdata  in  32  write data.
REQ-012 csr_rdata  out  32  combinational read of the selected word.
REQ-013 trap_req  out  1  FP exception trap pending.
REQ-014 trap_ack  in  1  trap taken by control.

Function
REQ-015 FCSR layout SHALL be: [1:0] RM (stored only), [6:2] sticky flags, [11:7] enables, [16:12] cause, [23] FCC; other bits read 0. Each 5-bit field SHALL be ordered {V,Z,O,U,I} from MSB to LSB.
REQ-016 Per-op cause SHALL be: V=snan|qnan, Z=dbz, O=overflow, U=underflow, I=inexact.
REQ-017 FSM states SHALL be IDLE and TRAP_PENDING; res_ready=1 only in IDLE with csr_we=0.
REQ-018 On accept, the cause field SHALL be overwritten with the op cause the next edge.
REQ-019 On accept with (cause&enables)==0: flags|=cause, FCC=zero, wb_valid=1 and wb_data=res_data for exactly the following cycle (1-cycle latency).
REQ-020 On accept with (cause&enables)!=0: flags and FCC unchanged, wb_valid stays 0, next state TRAP_PENDING.
REQ-021 trap_req SHALL equal (state==TRAP_PENDING).
REQ-022 TRAP_PENDING -> IDLE on the edge where trap_ack=1; trap_ack in IDLE is ignored.
REQ-023 csr_we with csr_sel=0 SHALL load all defined FCSR fields from csr_wdata; it is legal in either state.
REQ-024 A CSR write never raises a trap, even if the written cause&enables is nonzero.
REQ-025 Simultaneous csr_we and trap_ack SHALL both take effect on the same edge.
REQ-026 Back-to-back accepts SHALL sustain one result per cycle while no trap fires.

Reset
REQ-027 On rst_n=0: state=IDLE, FCSR=0, wb_valid=0, wb_data=0, trap_req=0, counters=0.
REQ-028 Reset mid-trap SHALL drop the pending trap immediately, without waiting for a clock edge.

Configuration
REQ-029 With FPU_CSR_STATS_EN defined: the stats word is {trap_cnt[15:0], op_cnt[15:0]}.
REQ-030 op_cnt SHALL increment on each accept; trap_cnt SHALL increment on each transition to TRAP_PENDING. Both counters saturate at 16'hFFFF.
REQ-031 A csr_we with csr_sel=1 SHALL clear both counters.
REQ-032 Without FPU_CSR_STATS_EN: a read with csr_sel=1 returns 0, a write with csr_sel=1 is ignored, and no counter logic is built.

Structure
REQ-033 Package fpu_pkg SHALL hold FCSR field bit positions, cause-bit indices, the res_flags index constants and the state enum.
REQ-034 One sub-module, fpu_sat_counter (parameterised width, inc, clr), SHALL implement each stats counter.

Verification
REQ-035 Enables=0; accept res_flags with inexact=1 and res_data=32'h3F800000 -> next cycle wb_valid=1 with wb_data=32'h3F800000; FCSR[2]=1 and FCSR[12]=1.
REQ-036 Enables Z set (write 32'h00000400); accept with dbz=1 -> trap_req=1, res_ready=0, wb_valid=0, flags=0, cause[15]=1; trap_ack -> IDLE next cycle.
REQ-037 Three back-to-back accepts with overflow, underflow, then none -> flags=5'b00110 and cause=0 after the third.
REQ-038 csr_we with csr_wdata=32'h0001F800 while idle -> no trap_req; res_ready=0 during the write cycle.
REQ-039 Assert rst_n low asynchronously during TRAP_PENDING -> trap_req falls before the next clk edge and FCSR reads 0.
REQ-040 STATS_EN: 65540 clean accepts -> op_cnt=16'hFFFF; csr_sel=1 write -> reads 32'h0.
